// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add 32x32 unsigned multiply sequencer driving the shared ALU
//
// Purpose: computes HI:LO = op_a * op_b (unsigned) over 32 cycles, using the
// shared ALU as the adder for one add per cycle. Sits beside the EX stage;
// while o_busy is high the EX stage stalls and the ALU input mux selects this
// block's o_alu_ctrl/o_alu_a/o_alu_b.
//
// Ports:
//   i_clk         rising-edge clock
//   i_reset       asynchronous active-high reset
//   i_start       one-cycle request; operands sampled with it (ignored while busy)
//   i_op_a        multiplicand
//   i_op_b        multiplier
//   o_busy        high in CALC and DONE
//   o_done        one-cycle pulse; o_hi/o_lo valid from this cycle
//   o_hi, o_lo    registered upper/lower product words
//   o_alu_ctrl    ALU control (add while calculating, AND otherwise)
//   o_alu_a/b     ALU operands
//   i_alu_result  ALU result, combinational in the same cycle
module alu_mul_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] ALU_ADD  = 3'b010,
    parameter logic [2:0] ALU_IDLE = 3'b000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [2:0]       o_alu_ctrl,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [5:0]         r_count;
    logic [WIDTH-1:0]   r_mcand;
    // Product register {upper, lower}. The adder's carry-out always lands in
    // the top bit after the right shift, so no extra pre-shift carry bit is
    // ever held across a clock edge.
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_carry;
    logic               w_last;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_last = (r_count == 6'(WIDTH - 1));

    always_comb begin
        w_next_state = r_state;
        o_alu_ctrl   = ALU_IDLE;
        o_alu_a      = '0;
        o_alu_b      = '0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                o_alu_ctrl = ALU_ADD;
                o_alu_a    = r_prod[2*WIDTH-1:WIDTH];
                o_alu_b    = r_prod[0] ? r_mcand : '0;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The ALU does not export its carry; an unsigned wrap shows up as the sum
    // being smaller than the A operand. Gated so a zero addend never carries.
    assign w_carry     = (o_alu_b != '0) && (i_alu_result < o_alu_a);
    assign w_prod_next = {w_carry, i_alu_result, r_prod[WIDTH-1:1]};

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // i_alu_result is only consumed in CALC, so whatever the ALU produces in
    // other states never reaches a register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_op_a;
                        r_prod  <= {{WIDTH{1'b0}}, i_op_b};
                        r_count <= '0;
                    end
                end
                CALC: begin
                    r_prod  <= w_prod_next;
                    r_count <= r_count + 6'd1;
                    // Capture the final shifted product directly so hi/lo are
                    // already valid in the DONE cycle.
                    if (w_last) begin
                        r_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_next[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for alu_mul_sequencer
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] junk;

    int n_chk     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int last_done = -1;
    int done_gap  = 0;

    alu_mul_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_hi         (hi),
        .o_lo         (lo),
        .o_alu_ctrl   (alu_ctrl),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU stand-in: a real adder when asked to add, random garbage
    // otherwise so any leak of the result outside CALC corrupts the product.
    always @(negedge clk) junk <= $urandom;
    assign alu_result = (alu_ctrl == 3'b010) ? (alu_a + alu_b) : junk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Drives start for one cycle, then
    // watches 34 cycles (k = 1..34 after the sampling edge). g1/g2 pulse a
    // spurious start (operands 2*2) at that k. Returns at negedge k=34, which
    // is the cycle after done, so an immediate next call is back-to-back.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int g1, input int g2);
        logic [63:0] exp;
        int n_busy;
        int n_add;
        int n_done;
        int n_bnz;
        int done_k;
        exp    = {32'b0, a} * {32'b0, b};
        n_busy = 0;
        n_add  = 0;
        n_done = 0;
        n_bnz  = 0;
        done_k = -1;
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start = (k == g1) || (k == g2);
            op_a  = start ? 32'd2 : $urandom;
            op_b  = start ? 32'd2 : $urandom;
            if (busy) n_busy++;
            if (alu_ctrl == 3'b010) n_add++;
            if (alu_b != 32'd0) n_bnz++;
            if (done) begin
                n_done++;
                done_k = k;
                chk("hi_at_done", {32'b0, hi}, {32'b0, exp[63:32]});
                chk("lo_at_done", {32'b0, lo}, {32'b0, exp[31:0]});
                if (last_done >= 0) done_gap = cyc - last_done;
                last_done = cyc;
            end
        end
        start = 1'b0;
        chk("done_latency", 64'(done_k), 64'd33);
        chk("done_pulses", 64'(n_done), 64'd1);
        chk("busy_cycles", 64'(n_busy), 64'd33);
        chk("add_cycles", 64'(n_add), 64'd32);
        chk("busy_after", {63'b0, busy}, 64'd0);
        chk("hi_hold", {32'b0, hi}, {32'b0, exp[63:32]});
        chk("lo_hold", {32'b0, lo}, {32'b0, exp[31:0]});
        if (a == 32'd0 || b == 32'd0) chk("alu_b_zero", 64'(n_bnz), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n_late;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_ctrl", {61'b0, alu_ctrl}, 64'd0);
        chk("rst_alu_a", {32'b0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'b0, alu_b}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_mul(32'd3, 32'd5, -1, -1);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        do_mul(32'h8000_0000, 32'd2, -1, -1);
        do_mul(32'h1234_5678, 32'd0, -1, -1);
        do_mul(32'd0, 32'hDEAD_BEEF, -1, -1);
        do_mul(32'd7, 32'd9, 10, 33);
        do_mul(32'd6, 32'd7, -1, -1);

        // Reset in the middle of a calculation.
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        chk("midrst_ctrl", {61'b0, alu_ctrl}, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_late = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) n_late++;
        end
        chk("no_done_after_rst", 64'(n_late), 64'd0);
        do_mul(32'd4, 32'd4, -1, -1);

        // Back-to-back: second start lands in the cycle after done.
        @(negedge clk);
        last_done = -1;
        done_gap  = 0;
        do_mul(32'h0001_0000, 32'h0001_0000, -1, -1);
        do_mul(32'h0000_FFFF, 32'd2, -1, -1);
        chk("b2b_gap", 64'(done_gap), 64'd34);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = pick();
            rb = pick();
            do_mul(ra, rb, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
